// File: rtl/mux_serializer_11_1_pkg.sv
// Shared constants and FSM encoding for the 11-lane serializer.
package mux_serializer_11_1_pkg;

  localparam int unsigned LANES     = 11;
  localparam int unsigned SEL_WIDTH = 4;

  typedef enum logic {
    StIdle = 1'b0,
    StSend = 1'b1
  } state_e;

endpackage

// File: rtl/mux_serializer_11_1_prio_enc_11.sv
// Lowest-set-bit priority encoder over the 11-lane pending mask.
module mux_serializer_11_1_prio_enc_11
  import mux_serializer_11_1_pkg::*;
(
  input  logic [LANES-1:0]     mask,
  output logic [SEL_WIDTH-1:0] idx,
  output logic                 found
);

  // Scan downwards so the lowest set bit is the last (winning) assignment.
  always_comb begin
    idx = '0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (mask[i]) idx = SEL_WIDTH'(i);
    end
  end

  assign found = |mask;

endmodule

// File: rtl/mux_serializer_11_1.sv
// Captures 11 lane words plus a valid mask, then emits pending lanes in ascending
// index order over a valid/ready output.
module mux_serializer_11_1
  import mux_serializer_11_1_pkg::*;
#(
  parameter int unsigned INPUT_DATA_WIDTH = 8
) (
  input  logic                        MSER_CLOCK_50,
  input  logic                        MSER_RESET_InHigh,
  input  logic [INPUT_DATA_WIDTH-1:0] MSER_Data_in0,
  input  logic [INPUT_DATA_WIDTH-1:0] MSER_Data_in1,
  input  logic [INPUT_DATA_WIDTH-1:0] MSER_Data_in2,
  input  logic [INPUT_DATA_WIDTH-1:0] MSER_Data_in3,
  input  logic [INPUT_DATA_WIDTH-1:0] MSER_Data_in4,
  input  logic [INPUT_DATA_WIDTH-1:0] MSER_Data_in5,
  input  logic [INPUT_DATA_WIDTH-1:0] MSER_Data_in6,
  input  logic [INPUT_DATA_WIDTH-1:0] MSER_Data_in7,
  input  logic [INPUT_DATA_WIDTH-1:0] MSER_Data_in8,
  input  logic [INPUT_DATA_WIDTH-1:0] MSER_Data_in9,
  input  logic [INPUT_DATA_WIDTH-1:0] MSER_Data_in10,
  input  logic [LANES-1:0]            MSER_Valid_in,
  input  logic                        MSER_Load,
  input  logic                        MSER_Out_ready,
  output logic [INPUT_DATA_WIDTH-1:0] MSER_Data_out,
  output logic [SEL_WIDTH-1:0]        MSER_Sel_out,
  output logic                        MSER_Out_valid,
  output logic                        MSER_Busy,
  output logic                        MSER_Done
);

  state_e                      state_q, state_d;
  logic [LANES-1:0]            pending_q, pending_d;
  logic [INPUT_DATA_WIDTH-1:0] bank_q [LANES];
  logic [INPUT_DATA_WIDTH-1:0] bank_d [LANES];
  logic [INPUT_DATA_WIDTH-1:0] data_in [LANES];
  logic                        done_q, done_d;
  logic [SEL_WIDTH-1:0]        sel;
  logic                        found;
  logic                        out_valid;

  always_comb begin
    data_in[0]  = MSER_Data_in0;
    data_in[1]  = MSER_Data_in1;
    data_in[2]  = MSER_Data_in2;
    data_in[3]  = MSER_Data_in3;
    data_in[4]  = MSER_Data_in4;
    data_in[5]  = MSER_Data_in5;
    data_in[6]  = MSER_Data_in6;
    data_in[7]  = MSER_Data_in7;
    data_in[8]  = MSER_Data_in8;
    data_in[9]  = MSER_Data_in9;
    data_in[10] = MSER_Data_in10;
  end

  mux_serializer_11_1_prio_enc_11 u_prio_enc (
    .mask  (pending_q),
    .idx   (sel),
    .found (found)
  );

  assign out_valid = (state_q == StSend) && found;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    bank_d    = bank_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (MSER_Load) begin
          bank_d    = data_in;
          pending_d = MSER_Valid_in;
          if (|MSER_Valid_in) state_d = StSend;
          else                done_d  = 1'b1;
        end
      end
      StSend: begin
        if (out_valid && MSER_Out_ready) begin
          pending_d = pending_q & ~(LANES'(1) << sel);
          if (pending_d == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge MSER_CLOCK_50) begin
    if (MSER_RESET_InHigh) begin
      state_q   <= StIdle;
      pending_q <= '0;
      done_q    <= 1'b0;
      for (int k = 0; k < int'(LANES); k++) bank_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      bank_q    <= bank_d;
    end
  end

  // Output comes only from the captured bank, never from the live inputs.
  assign MSER_Data_out  = out_valid ? bank_q[sel] : '0;
  assign MSER_Sel_out   = out_valid ? sel : '0;
  assign MSER_Out_valid = out_valid;
  assign MSER_Busy      = (state_q == StSend);
  assign MSER_Done      = done_q;

endmodule

// File: doc/mux_serializer_11_1.md
MUX_SERIALIZER_11_1 -- requirements
Module: MUX_SERIALIZER_11_1

Interface
REQ-001 Parameter INPUT_DATA_WIDTH, default 8, bit width of every lane and of the output data bus.
REQ-002 MSER_CLOCK_50  input  1  single clock; all state updates on its rising edge.
REQ-003 MSER_RESET_InHigh  input  1  reset; synchronous and active-high.
REQ-004 MSER_Data_in0 .. MSER_Data_in10  input  INPUT_DATA_WIDTH each  the 11 lane data words.
REQ-005 MSER_Valid_in  input  11  per-lane valid mask; bit k qualifies MSER_Data_ink.
REQ-006 MSER_Load  input  1  capture strobe for all 11 lanes plus mask.
REQ-007 MSER_Out_ready  input  1  downstream ready.
REQ-008 MSER_Data_out  output  INPUT_DATA_WIDTH  serialized lane word; all-zero whenever MSER_Out_valid=0.
REQ-009 MSER_Sel_out  output  4  lane index of MSER_Data_out, 4'd0..4'd10 (same encoding as the 1-to-11 demux selector); 4'd0 when not valid.
REQ-010 MSER_Out_valid  output  1  output word valid.
REQ-011 MSER_Busy  output  1  high while a captured batch is being serialized.
REQ-012 MSER_Done  output  1  one-cycle pulse at batch completion.

Function
REQ-013 States SHALL be IDLE and SEND; MSER_Busy SHALL equal (state==SEND).
REQ-014 In IDLE, MSER_Load=1 SHALL capture all 11 data words into a register bank and MSER_Valid_in into an 11-bit pending mask in the same edge.
REQ-015 Load with nonzero mask SHALL move IDLE->SEND; MSER_Out_valid SHALL rise the cycle after the load (latency 1).
REQ-016 Load with all-zero mask SHALL stay in IDLE and pulse MSER_Done the following cycle; no output word is produced.
REQ-017 MSER_Load while in SEND SHALL be ignored; captured data and mask remain unchanged.
REQ-018 In SEND, the output SHALL present the lowest-index pending lane (data and index).
REQ-019 A handshake (MSER_Out_valid & MSER_Out_ready) SHALL clear that lane's pending bit; the next pending lane SHALL appear the following cycle with no bubble.
REQ-020 While MSER_Out_valid=1 and MSER_Out_ready=0, MSER_Data_out and MSER_Sel_out SHALL hold stable.
REQ-021 Handshake on the last pending lane SHALL return SEND->IDLE; MSER_Done SHALL pulse for exactly one cycle in the next cycle, with MSER_Busy=0 and MSER_Out_valid=0.
REQ-022 A load in the cycle MSER_Done is high SHALL be accepted (back-to-back batches, one-cycle gap).
REQ-023 Lanes with pending bit 0 SHALL never be emitted; emission order is strictly ascending index.

Reset
REQ-024 Reset SHALL force IDLE, pending mask 0, register bank 0, MSER_Out_valid=0, MSER_Busy=0, MSER_Done=0, MSER_Data_out=0, MSER_Sel_out=0.
REQ-025 Reset asserted mid-batch SHALL discard all pending lanes; no MSER_Done pulse SHALL follow.
REQ-026 Reset SHALL take priority over MSER_Load in the same cycle.

Structure
REQ-027 A shared package SHALL hold LANES=11, SEL_WIDTH=4, and the IDLE/SEND state encodings.
REQ-028 Lowest-set-bit selection SHALL be a sub-module PRIO_ENC_11 (11-bit mask in; 4-bit index and found flag out; purely combinational).
REQ-029 Register bank, pending mask and FSM SHALL reside in MUX_SERIALIZER_11_1; output data driven from a registered or bank-indexed path with no combinational path from MSER_Data_in* to MSER_Data_out.

Verification
REQ-030 Load mask 11'h7FF, data lane k = 8'h10+k, ready=1 constantly -> 11 consecutive words 8'h10..8'h1A, Sel 0..10, Done pulse one cycle after the 8'h1A handshake.
REQ-031 Load mask 11'b100_0000_0101, ready=1 -> words from lanes 0, 2, 10 only, on three consecutive cycles, then Done.
REQ-032 Mask 11'h003, ready=0 for 5 cycles then 1 -> lane 0 word held stable 5 cycles, then lanes 0 and 1 emitted, then Done.
REQ-033 Load mask 0 -> no MSER_Out_valid, Done pulses one cycle after load, Busy stays 0.
REQ-034 Load mask 11'h7FF, assert reset after 3 handshakes -> all outputs 0 the cycle after reset, no Done; subsequent load of mask 11'h001 emits lane 0 normally.
REQ-035 Second MSER_Load during SEND with different data -> ignored, first batch emitted intact; a load in the Done cycle starts a new batch.
